// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional branch prediction is enabled by defining BTB_PREDICT_EN; when it is not
// defined there is no BTB storage and the fetch stream is never predicted.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] EXC_VECTOR = 32'hF0000000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrData,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Exception,
  input  logic        UpdValid,
  input  logic        UpdTaken,
  input  logic [31:0] UpdPC,
  input  logic [31:0] UpdTarget,
  output logic [31:0] IDInstr,
  output logic [31:0] IDPC4,
  output logic        IDValid,
  output logic        IDPredTaken
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h00000000;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic            id_valid_q, id_valid_d;
  logic            id_pred_q, id_pred_d;

  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            squash;

`ifdef BTB_PREDICT_EN
  localparam int unsigned BTB_ENTRIES = 4;
  localparam int unsigned TAG_W       = 28;
  // Targets are word aligned, so only bits [31:2] are kept.
  localparam int unsigned TGT_W       = 30;

  logic [BTB_ENTRIES-1:0]             btb_valid_q, btb_valid_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  btb_tag_q, btb_tag_d;
  logic [BTB_ENTRIES-1:0][TGT_W-1:0]  btb_tgt_q, btb_tgt_d;
  logic [BTB_ENTRIES-1:0][1:0]        btb_ctr_q, btb_ctr_d;
  logic [1:0]                         lk_idx;
  logic [1:0]                         up_idx;
  logic                               up_hit;
  logic                               unused_bits;

  assign lk_idx      = pc_q[3:2];
  assign up_idx      = UpdPC[3:2];
  assign unused_bits = ^{RedirectPC[1:0], UpdPC[1:0], UpdTarget[1:0]};

  // Lookup reads the registered (pre-update) entry for the current PC.
  always_comb begin
    pred_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == pc_q[31:4])
                  && btb_ctr_q[lk_idx][1];
    pred_target = {btb_tgt_q[lk_idx], 2'b00};
  end

  // Branch-resolution update: train counter on hit, allocate on taken miss.
  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    btb_ctr_d   = btb_ctr_q;
    up_hit      = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == UpdPC[31:4]);
    if (UpdValid) begin
      if (up_hit) begin
        if (UpdTaken) begin
          if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'd1;
        end else begin
          if (btb_ctr_q[up_idx] != 2'b00) btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'd1;
        end
        btb_tgt_d[up_idx] = UpdTarget[31:2];
      end else if (UpdTaken) begin
        btb_valid_d[up_idx] = 1'b1;
        btb_tag_d[up_idx]   = UpdPC[31:4];
        btb_tgt_d[up_idx]   = UpdTarget[31:2];
        btb_ctr_d[up_idx]   = 2'b10;
      end
    end
  end

  // BTB state: entries invalid with weakly-not-taken counters out of reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      btb_valid_q <= '0;
      btb_tag_q   <= '0;
      btb_tgt_q   <= '0;
      btb_ctr_q   <= {BTB_ENTRIES{2'b01}};
    end else begin
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
      btb_ctr_q   <= btb_ctr_d;
    end
  end
`else
  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign pred_target = '0;
  assign unused_bits = ^{RedirectPC[1:0], UpdValid, UpdTaken, UpdPC, UpdTarget};
`endif

  assign InstrAddr   = pc_q;
  assign IDInstr     = id_instr_q;
  assign IDPC4       = id_pc4_q;
  assign IDValid     = id_valid_q;
  assign IDPredTaken = id_pred_q;

  assign squash = Exception || Redirect || Flush;

  // Next-PC priority: exception, redirect, stall, prediction, sequential.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    if (Exception) begin
      pc_d = {EXC_VECTOR[31:2], 2'b00};
    end else if (Redirect) begin
      pc_d = {RedirectPC[31:2], 2'b00};
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // IF/ID register: bubble on squash, hold on stall, otherwise capture the fetch.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    id_pred_d  = id_pred_q;
    if (squash) begin
      id_instr_d = NOP;
      id_pc4_d   = '0;
      id_valid_d = 1'b0;
      id_pred_d  = 1'b0;
    end else if (!Stall) begin
      id_instr_d = InstrData;
      id_pc4_d   = pc_plus4;
      id_valid_d = 1'b1;
      id_pred_d  = pred_taken;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q       <= {RESET_PC[31:2], 2'b00};
      id_instr_q <= NOP;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      id_pred_q  <= id_pred_d;
    end
  end

endmodule
